w_serial_fir: RTL

W_SERIAL_FIR -- requirements
Module: w_serial_fir

---
 rtl/w_serial_fir_if.sv | 25 ++
 rtl/w_serial_fir.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/w_serial_fir_if.sv
// Sample-in / result-out bundle for w_serial_fir.
// A sample transfers on a rising edge where valid_in && ready_in; valid_out is a one-cycle strobe with no backpressure.
interface w_serial_fir_if #(
   parameter int IN_W  = 32,
   parameter int OUT_W = 32,
   parameter int CH_W  = 3
) ();
   logic                    valid_in;
   logic                    ready_in;
   logic [CH_W-1:0]         ch_in;
   logic signed [IN_W-1:0]  data_in;
   logic signed [OUT_W-1:0] data_out;
   logic [CH_W-1:0]         ch_out;
   logic                    valid_out;

   modport master (
      output valid_in, ch_in, data_in,
      input  ready_in, data_out, ch_out, valid_out
   );

   modport slave (
      input  valid_in, ch_in, data_in,
      output ready_in, data_out, ch_out, valid_out
   );
endinterface

// File: rtl/w_serial_fir.sv
// Multi-channel serial FIR: one MAC per clock over N taps, per-channel weights and
// sample histories, runtime weight overwrite/accumulate and coefficient readback.
module w_serial_fir #(
   parameter int  N         = 32,
   parameter int  CH        = 4,
   parameter int  IN_W      = 32,
   parameter int  OUT_W     = 32,
   parameter int  COEFF_W   = 32,
   parameter int  R_IN      = 31,
   parameter int  R_OUT     = 31,
   parameter int  R_COEFF   = 30,
   localparam int SHIFT_VAL = R_COEFF + R_IN - R_OUT,
   localparam int ACC_W     = IN_W + COEFF_W + $clog2(N),
   // One spare code point above CH-1 so out-of-range channels can be presented and flagged.
   localparam int CH_W      = $clog2(CH + 1),
   localparam int N_W       = $clog2(N)
) (
   input  logic                        clock,
   input  logic                        reset,
   w_serial_fir_if.slave               bus,
   input  logic                        weight_load_en,
   input  logic                        weight_mode,
   input  logic [CH_W-1:0]             weight_ch,
   input  logic [N-1:0][COEFF_W-1:0]   weight_in,
   input  logic [CH_W-1:0]             output_ch,
   input  logic [N_W-1:0]              output_idx,
   output logic signed [COEFF_W-1:0]   output_coeff,
   output logic                        ch_err,
   output logic [1:0]                  fsm_state
);

   localparam int PROD_W = IN_W + COEFF_W;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      MAC  = 2'd1,
      OUT  = 2'd2
   } state_e;

   state_e state_q, state_d;

   logic signed [COEFF_W-1:0] w_q    [CH][N];
   logic signed [IN_W-1:0]    hist_q [CH][N-1];

   logic signed [IN_W-1:0]    x_q;
   logic [CH_W-1:0]           ch_q;
   logic [N_W-1:0]            tap_q;
   logic signed [ACC_W-1:0]   acc_q;

   logic in_ch_ok, wt_ch_ok;
   logic accept, drop, wt_apply, wt_bad, last_tap;

   logic signed [COEFF_W-1:0] w_row   [N];
   logic signed [IN_W-1:0]    h_row   [N-1];
   logic signed [COEFF_W-1:0] wt_row  [N];
   logic signed [COEFF_W-1:0] wt_next [N];
   logic signed [IN_W-1:0]    tap_x;
   logic signed [COEFF_W-1:0] tap_w;
   logic signed [PROD_W-1:0]  prod, prod_sh;
   logic signed [ACC_W-1:0]   prod_ext;
   logic [ACC_W-OUT_W:0]      acc_hi;
   logic signed [OUT_W-1:0]   acc_sat;

   function automatic logic signed [COEFF_W-1:0] sat_add(
      input logic signed [COEFF_W-1:0] a,
      input logic signed [COEFF_W-1:0] b
   );
      logic signed [COEFF_W:0] sum;
      sum = {a[COEFF_W-1], a} + {b[COEFF_W-1], b};
      if (sum[COEFF_W] != sum[COEFF_W-1])
         sat_add = sum[COEFF_W] ? {1'b1, {(COEFF_W-1){1'b0}}} : {1'b0, {(COEFF_W-1){1'b1}}};
      else
         sat_add = sum[COEFF_W-1:0];
   endfunction

   assign in_ch_ok     = (int'(bus.ch_in) < CH);
   assign wt_ch_ok     = (int'(weight_ch) < CH);
   assign accept       = bus.valid_in && (state_q == IDLE) && in_ch_ok;
   assign drop         = bus.valid_in && (state_q == IDLE) && !in_ch_ok;
   assign wt_apply     = weight_load_en && (state_q == IDLE) && wt_ch_ok;
   assign wt_bad       = weight_load_en && !wt_ch_ok;
   assign last_tap     = (int'(tap_q) == N - 1);
   assign bus.ready_in = (state_q == IDLE);
   assign fsm_state    = state_q;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) state_q <= IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (accept) state_d = MAC;
         MAC:     if (last_tap) state_d = OUT;
         OUT:     state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Row views of the captured channel (for the MAC) and of weight_ch (for updates).
   always_comb begin
      for (int i = 0; i < N; i++) begin
         w_row[i]  = '0;
         wt_row[i] = '0;
      end
      for (int j = 0; j < N - 1; j++) h_row[j] = '0;
      for (int c = 0; c < CH; c++) begin
         if (int'(ch_q) == c) begin
            for (int i = 0; i < N; i++)     w_row[i] = w_q[c][i];
            for (int j = 0; j < N - 1; j++) h_row[j] = hist_q[c][j];
         end
         if (int'(weight_ch) == c)
            for (int i = 0; i < N; i++) wt_row[i] = w_q[c][i];
      end
   end

   always_comb begin
      tap_x = x_q;
      tap_w = '0;
      for (int i = 0; i < N; i++)
         if (int'(tap_q) == i) tap_w = w_row[i];
      for (int j = 0; j < N - 1; j++)
         if (int'(tap_q) == j + 1) tap_x = h_row[j];
   end

   assign prod     = tap_x * tap_w;
   assign prod_sh  = prod >>> SHIFT_VAL;
   assign prod_ext = {{(ACC_W - PROD_W){prod_sh[PROD_W-1]}}, prod_sh};

   // The accumulator fits in OUT_W bits only when all bits from OUT_W-1 up agree.
   assign acc_hi = acc_q[ACC_W-1:OUT_W-1];
   always_comb begin
      if ((&acc_hi) || !(|acc_hi))
         acc_sat = acc_q[OUT_W-1:0];
      else if (acc_q[ACC_W-1])
         acc_sat = {1'b1, {(OUT_W-1){1'b0}}};
      else
         acc_sat = {1'b0, {(OUT_W-1){1'b1}}};
   end

   always_comb begin
      for (int i = 0; i < N; i++)
         wt_next[i] = weight_mode ? $signed(weight_in[i])
                                  : sat_add(wt_row[i], $signed(weight_in[i]));
   end

   always_comb begin
      output_coeff = '0;
      for (int c = 0; c < CH; c++)
         for (int i = 0; i < N; i++)
            if ((int'(output_ch) == c) && (int'(output_idx) == i))
               output_coeff = w_q[c][i];
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         x_q           <= '0;
         ch_q          <= '0;
         tap_q         <= '0;
         acc_q         <= '0;
         bus.data_out  <= '0;
         bus.ch_out    <= '0;
         bus.valid_out <= 1'b0;
         ch_err        <= 1'b0;
      end else begin
         bus.valid_out <= 1'b0;
         if (drop || wt_bad) ch_err <= 1'b1;
         case (state_q)
            IDLE: begin
               if (accept) begin
                  x_q   <= bus.data_in;
                  ch_q  <= bus.ch_in;
                  acc_q <= '0;
                  tap_q <= '0;
               end
            end
            MAC: begin
               acc_q <= acc_q + prod_ext;
               tap_q <= tap_q + N_W'(1);
            end
            OUT: begin
               bus.data_out  <= acc_sat;
               bus.ch_out    <= ch_q;
               bus.valid_out <= 1'b1;
            end
            default: ;
         endcase
      end
   end

   // History shifts only on the result edge, so an aborted MAC leaves it intact.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         for (int c = 0; c < CH; c++) begin
            for (int i = 0; i < N; i++)     w_q[c][i]    <= '0;
            for (int j = 0; j < N - 1; j++) hist_q[c][j] <= '0;
         end
      end else begin
         for (int c = 0; c < CH; c++) begin
            if (wt_apply && (int'(weight_ch) == c))
               for (int i = 0; i < N; i++) w_q[c][i] <= wt_next[i];
            if ((state_q == OUT) && (int'(ch_q) == c)) begin
               hist_q[c][0] <= x_q;
               for (int j = 1; j < N - 1; j++) hist_q[c][j] <= hist_q[c][j-1];
            end
         end
      end
   end

endmodule
